uart_rx_cmd_ctrl: RTL and testbench

- Frame controller downstream of the UART receiver (3.125 MHz domain, 27 clocks per bit, 8 data bits plus parity).
- Turns the receiver's per-byte output (rx_msg / rx_complete) into validated maze-solver command packets.
- Sequences a frame through SOF, OPCODE, LEN, PAYLOAD and CHK, with an inter-byte timeout and error reporting.
- Hands finished commands to the solver core over a valid/ready handshake.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_frame_timer.sv | 28 ++
 rtl/uart_rx_cmd_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_rx_cmd_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: bit timing, framing bytes, error codes and the
// receive command-controller state encoding.
package uart_pkg;

   localparam int BIT_DURATION = 27;

   localparam logic [7:0] SOF_BYTE_DEF = 8'h23;
   localparam logic [7:0] ERR_BYTE_DEF = 8'h3F;

   localparam logic [2:0] ERR_NONE     = 3'd0;
   localparam logic [2:0] ERR_LEN      = 3'd1;
   localparam logic [2:0] ERR_CHK      = 3'd2;
   localparam logic [2:0] ERR_PARITY   = 3'd3;
   localparam logic [2:0] ERR_TIMEOUT  = 3'd4;
   localparam logic [2:0] ERR_OVERRUN  = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_OPC  = 3'd1,
      ST_LEN  = 3'd2,
      ST_PAY  = 3'd3,
      ST_CHK  = 3'd4,
      ST_HOLD = 3'd5
   } rx_state_e;

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte timeout counter: clears on clr, counts while en, and flags the
// cycle in which the count sits at LIMIT-1.
module uart_frame_timer #(
   parameter int LIMIT = 2700
) (
   input  logic clk_3125,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

   logic [W-1:0] count_q;

   // NOTE: sequential state is written with <= so every register samples pre-edge values.
   always_ff @(posedge clk_3125) begin
      if (rst || clr) begin
         count_q <= '0;
      end else if (en) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign expired = en && (count_q == W'(LIMIT - 1));

endmodule

// File: rtl/uart_rx_cmd_ctrl.sv
// Frame controller behind the UART receiver: assembles SOF/OPCODE/LEN/PAYLOAD/CHK
// frames into command packets and presents them over a valid/ready handshake.
module uart_rx_cmd_ctrl
   import uart_pkg::*;
#(
   parameter int         MAX_LEN     = 8,
   parameter int         TIMEOUT_CYC = 2700,
   parameter logic [7:0] SOF_BYTE    = SOF_BYTE_DEF,
   parameter logic [7:0] ERR_BYTE    = ERR_BYTE_DEF
) (
   input  logic                 clk_3125,
   input  logic                 rst,
   input  logic [7:0]           rx_msg,
   input  logic                 rx_complete,
   input  logic                 cmd_ready,
   output logic                 cmd_valid,
   output logic [7:0]           cmd_opcode,
   output logic [3:0]           cmd_len,
   output logic [8*MAX_LEN-1:0] cmd_payload,
   output logic                 err_pulse,
   output logic [2:0]           err_code,
   output logic                 busy
);

   rx_state_e state_q, state_d;

   logic                   rx_complete_q;
   logic                   stb;
   logic                   frame_active;
   logic                   tmr_expired;

   logic [7:0]             opcode_q;
   logic [3:0]             len_q;
   logic [3:0]             idx_q;
   logic [7:0]             chk_q;
   logic [MAX_LEN-1:0][7:0] pay_q;

   logic                   ld_opc;
   logic                   ld_len;
   logic                   wr_pay;
   logic                   chk_clr;
   logic                   chk_xor;
   logic                   idx_clr;
   logic                   idx_inc;
   logic                   cmd_load;
   logic                   cmd_accept;
   logic                   err_set;
   logic [2:0]             err_d;

   assign stb          = rx_complete & ~rx_complete_q;
   assign frame_active = state_q inside {ST_OPC, ST_LEN, ST_PAY, ST_CHK};
   assign busy         = (state_q != ST_IDLE);

   uart_frame_timer #(
      .LIMIT (TIMEOUT_CYC)
   ) u_timer (
      .clk_3125 (clk_3125),
      .rst      (rst),
      .clr      (stb || !frame_active),
      .en       (frame_active),
      .expired  (tmr_expired)
   );

   always_ff @(posedge clk_3125) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every signal gets a default first so no branch can infer a latch.
   always_comb begin
      state_d    = state_q;
      ld_opc     = 1'b0;
      ld_len     = 1'b0;
      wr_pay     = 1'b0;
      chk_clr    = 1'b0;
      chk_xor    = 1'b0;
      idx_clr    = 1'b0;
      idx_inc    = 1'b0;
      cmd_load   = 1'b0;
      cmd_accept = 1'b0;
      err_set    = 1'b0;
      err_d      = ERR_NONE;

      // A parity-flagged byte aborts the frame before any other decoding of it.
      if (frame_active && stb && rx_msg == ERR_BYTE) begin
         err_set = 1'b1;
         err_d   = ERR_PARITY;
         state_d = ST_IDLE;
      end else if (frame_active && tmr_expired && !stb) begin
         err_set = 1'b1;
         err_d   = ERR_TIMEOUT;
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (stb && rx_msg == SOF_BYTE) begin
                  chk_clr = 1'b1;
                  state_d = ST_OPC;
               end
            end
            ST_OPC: begin
               if (stb) begin
                  ld_opc  = 1'b1;
                  chk_xor = 1'b1;
                  state_d = ST_LEN;
               end
            end
            ST_LEN: begin
               if (stb) begin
                  chk_xor = 1'b1;
                  if (rx_msg > 8'(MAX_LEN)) begin
                     err_set = 1'b1;
                     err_d   = ERR_LEN;
                     state_d = ST_IDLE;
                  end else begin
                     ld_len  = 1'b1;
                     idx_clr = 1'b1;
                     state_d = (rx_msg == 8'h00) ? ST_CHK : ST_PAY;
                  end
               end
            end
            ST_PAY: begin
               if (stb) begin
                  wr_pay  = 1'b1;
                  chk_xor = 1'b1;
                  if (idx_q == len_q - 4'd1) begin
                     state_d = ST_CHK;
                  end else begin
                     idx_inc = 1'b1;
                  end
               end
            end
            ST_CHK: begin
               if (stb) begin
                  if (rx_msg == chk_q) begin
                     cmd_load = 1'b1;
                     state_d  = ST_HOLD;
                  end else begin
                     err_set = 1'b1;
                     err_d   = ERR_CHK;
                     state_d = ST_IDLE;
                  end
               end
            end
            ST_HOLD: begin
               // A byte arriving with ready is treated as if the FSM were already idle.
               if (cmd_valid && cmd_ready) begin
                  cmd_accept = 1'b1;
                  if (stb && rx_msg == SOF_BYTE) begin
                     chk_clr = 1'b1;
                     state_d = ST_OPC;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else if (stb) begin
                  err_set = 1'b1;
                  err_d   = ERR_OVERRUN;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_3125) begin
      if (rst) begin
         // Seed the edge detector so a level already high is not taken as a new byte.
         rx_complete_q <= rx_complete;
         opcode_q      <= '0;
         len_q         <= '0;
         idx_q         <= '0;
         chk_q         <= '0;
         // NOTE: the payload buffer is reset explicitly so no stale data survives a reset.
         pay_q         <= '0;
         cmd_valid     <= 1'b0;
         cmd_opcode    <= '0;
         cmd_len       <= '0;
         cmd_payload   <= '0;
         err_pulse     <= 1'b0;
         err_code      <= ERR_NONE;
      end else begin
         rx_complete_q <= rx_complete;
         err_pulse     <= err_set;
         if (err_set) begin
            err_code <= err_d;
         end

         if (chk_clr) begin
            chk_q <= '0;
         end else if (chk_xor) begin
            chk_q <= chk_q ^ rx_msg;
         end

         if (ld_opc) begin
            opcode_q <= rx_msg;
         end
         if (ld_len) begin
            len_q <= rx_msg[3:0];
         end

         if (idx_clr) begin
            idx_q <= '0;
         end else if (idx_inc) begin
            idx_q <= idx_q + 4'd1;
         end

         for (int i = 0; i < MAX_LEN; i++) begin
            if (wr_pay && idx_q == 4'(i)) begin
               pay_q[i] <= rx_msg;
            end
         end

         // Command outputs only change when a frame is committed; bytes past len read as zero.
         if (cmd_load) begin
            cmd_valid  <= 1'b1;
            cmd_opcode <= opcode_q;
            cmd_len    <= len_q;
            for (int i = 0; i < MAX_LEN; i++) begin
               cmd_payload[8*i +: 8] <= (4'(i) < len_q) ? pay_q[i] : 8'h00;
            end
         end else if (cmd_accept) begin
            cmd_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Self-checking bench for uart_rx_cmd_ctrl: table-driven frames plus hand-written
// timing sequences, with a scoreboard queue matched against cmd_valid / err_pulse events.
module tb_uart_rx_cmd_ctrl;
   import uart_pkg::*;

   localparam int MAX_LEN     = 8;
   localparam int TIMEOUT_CYC = 2700;
   localparam int GAP_LONG    = BIT_DURATION * 11 - 2;
   localparam int GAP_SHORT   = 30;

   logic                 clk_3125 = 1'b0;
   logic                 rst;
   logic [7:0]           rx_msg;
   logic                 rx_complete;
   logic                 cmd_ready;
   logic                 cmd_valid;
   logic [7:0]           cmd_opcode;
   logic [3:0]           cmd_len;
   logic [8*MAX_LEN-1:0] cmd_payload;
   logic                 err_pulse;
   logic [2:0]           err_code;
   logic                 busy;

   typedef struct packed {
      logic        is_err;
      logic [2:0]  code;
      logic [7:0]  opc;
      logic [3:0]  len;
      logic [63:0] pay;
   } exp_t;

   typedef struct packed {
      logic [7:0]  opc;
      logic [7:0]  len_byte;
      logic [63:0] pay;
      logic [7:0]  chk_flip;
      logic [3:0]  par_pos;
      logic [2:0]  exp_err;
   } vec_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   logic valid_prev = 1'b0;

   uart_rx_cmd_ctrl #(
      .MAX_LEN     (MAX_LEN),
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .SOF_BYTE    (SOF_BYTE_DEF),
      .ERR_BYTE    (ERR_BYTE_DEF)
   ) dut (
      .clk_3125    (clk_3125),
      .rst         (rst),
      .rx_msg      (rx_msg),
      .rx_complete (rx_complete),
      .cmd_ready   (cmd_ready),
      .cmd_valid   (cmd_valid),
      .cmd_opcode  (cmd_opcode),
      .cmd_len     (cmd_len),
      .cmd_payload (cmd_payload),
      .err_pulse   (err_pulse),
      .err_code    (err_code),
      .busy        (busy)
   );

   always #5 clk_3125 = ~clk_3125;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic take_event(input logic is_err);
      exp_t e;
      if (sb.size() == 0) begin
         if (is_err) check("unexpected_err_pulse", 64'(err_pulse), 64'd0);
         else        check("unexpected_cmd_valid", 64'(cmd_valid), 64'd0);
      end else begin
         e = sb.pop_front();
         check("event_kind", 64'(is_err), 64'(e.is_err));
         if (is_err && e.is_err) begin
            check("ev_err_code", 64'(err_code), 64'(e.code));
         end else if (!is_err && !e.is_err) begin
            check("ev_opcode", 64'(cmd_opcode), 64'(e.opc));
            check("ev_len", 64'(cmd_len), 64'(e.len));
            check("ev_payload", cmd_payload, e.pay);
         end
      end
   endtask

   // Event monitor: samples on the falling edge, away from DUT updates.
   always @(negedge clk_3125) begin
      if (!rst) begin
         if (err_pulse) take_event(1'b1);
         if (cmd_valid && !valid_prev) take_event(1'b0);
      end
      valid_prev = cmd_valid;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk_3125);
      #1;
   endtask

   task automatic strobe(input logic [7:0] b);
      rx_msg      = b;
      rx_complete = 1'b1;
      tick(1);
   endtask

   // Keeps the level high one extra cycle so a held level must not re-trigger.
   task automatic release_rx();
      tick(1);
      rx_complete = 1'b0;
      rx_msg      = 8'h00;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      strobe(b);
      release_rx();
      tick(gap);
   endtask

   function automatic logic [63:0] mask_pay(input logic [63:0] p, input int len);
      logic [63:0] m;
      m = '0;
      for (int i = 0; i < 8; i++) begin
         if (i < len) m[8*i +: 8] = p[8*i +: 8];
      end
      return m;
   endfunction

   task automatic push_cmd(input logic [7:0] opc, input logic [3:0] len, input logic [63:0] pay);
      exp_t e;
      e = '{is_err: 1'b0, code: ERR_NONE, opc: opc, len: len, pay: pay};
      sb.push_back(e);
   endtask

   task automatic push_err(input logic [2:0] code);
      exp_t e;
      e = '{is_err: 1'b1, code: code, opc: 8'h00, len: 4'h0, pay: 64'h0};
      sb.push_back(e);
   endtask

   task automatic accept();
      int k;
      k = 0;
      while (!cmd_valid && k < 40) begin
         tick(1);
         k++;
      end
      check("valid_before_accept", 64'(cmd_valid), 64'd1);
      cmd_ready = 1'b1;
      tick(1);
      cmd_ready = 1'b0;
      check("valid_after_accept", 64'(cmd_valid), 64'd0);
      check("busy_after_accept", 64'(busy), 64'd0);
   endtask

   task automatic run_vec(input vec_t v);
      logic [7:0] fb [0:11];
      logic [7:0] chk;
      int         n;
      int         len;
      len   = int'(v.len_byte);
      fb[0] = SOF_BYTE_DEF;
      fb[1] = v.opc;
      fb[2] = v.len_byte;
      chk   = v.opc ^ v.len_byte;
      if (len <= MAX_LEN) begin
         for (int i = 0; i < len; i++) begin
            fb[3+i] = v.pay[8*i +: 8];
            chk     = chk ^ fb[3+i];
         end
         fb[3+len] = chk ^ v.chk_flip;
         n = 4 + len;
      end else begin
         n = 3;
      end
      if (v.par_pos != 4'd0) begin
         fb[v.par_pos] = ERR_BYTE_DEF;
         n = int'(v.par_pos) + 1;
      end
      if (v.exp_err == ERR_NONE) push_cmd(v.opc, v.len_byte[3:0], mask_pay(v.pay, len));
      else                       push_err(v.exp_err);
      for (int i = 0; i < n; i++) send_byte(fb[i], GAP_SHORT);
      if (v.exp_err == ERR_NONE) begin
         accept();
      end else begin
         check("vec_err_code", 64'(err_code), 64'(v.exp_err));
         check("vec_no_valid", 64'(cmd_valid), 64'd0);
         check("vec_idle", 64'(busy), 64'd0);
      end
   endtask

   initial begin
      #(80000 * 10);
      $display("FAIL watchdog: run exceeded its cycle budget");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vecs [9];
      vec_t v_good;
      vec_t v_zero;
      int   bad;

      vecs[0] = '{opc: 8'h10, len_byte: 8'h02, pay: 64'h4241,             chk_flip: 8'h03, par_pos: 4'd0, exp_err: ERR_CHK};
      vecs[1] = '{opc: 8'h10, len_byte: 8'h02, pay: 64'h4241,             chk_flip: 8'h00, par_pos: 4'd0, exp_err: ERR_NONE};
      vecs[2] = '{opc: 8'h10, len_byte: 8'h09, pay: 64'h0,                chk_flip: 8'h00, par_pos: 4'd0, exp_err: ERR_LEN};
      vecs[3] = '{opc: 8'h10, len_byte: 8'h01, pay: 64'h55,               chk_flip: 8'h00, par_pos: 4'd3, exp_err: ERR_PARITY};
      vecs[4] = '{opc: 8'h5A, len_byte: 8'h08, pay: 64'hF1E2D3C4B5A62323, chk_flip: 8'h00, par_pos: 4'd0, exp_err: ERR_NONE};
      vecs[5] = '{opc: 8'h01, len_byte: 8'h02, pay: 64'hBEEF,             chk_flip: 8'h00, par_pos: 4'd0, exp_err: ERR_NONE};
      vecs[6] = '{opc: 8'h20, len_byte: 8'h00, pay: 64'h0,                chk_flip: 8'h00, par_pos: 4'd0, exp_err: ERR_NONE};
      vecs[7] = '{opc: 8'h30, len_byte: 8'h01, pay: 64'hAA,               chk_flip: 8'h00, par_pos: 4'd4, exp_err: ERR_PARITY};
      vecs[8] = '{opc: 8'h30, len_byte: 8'h80, pay: 64'h0,                chk_flip: 8'h00, par_pos: 4'd0, exp_err: ERR_LEN};
      v_good  = vecs[1];
      v_zero  = vecs[6];

      // Reset with rx_complete already high: the held level must not start a frame.
      rst         = 1'b1;
      rx_complete = 1'b1;
      rx_msg      = SOF_BYTE_DEF;
      cmd_ready   = 1'b0;
      tick(3);
      check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
      check("rst_err_pulse", 64'(err_pulse), 64'd0);
      check("rst_err_code", 64'(err_code), 64'd0);
      check("rst_payload", cmd_payload, 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      rst = 1'b0;
      tick(2);
      check("held_level_no_stb", 64'(busy), 64'd0);
      rx_complete = 1'b0;
      tick(2);

      // Good frame at receiver byte spacing, latency and hold stability.
      push_cmd(8'h10, 4'd2, 64'h4241);
      send_byte(8'h23, GAP_LONG);
      send_byte(8'h10, GAP_LONG);
      send_byte(8'h02, GAP_LONG);
      send_byte(8'h41, GAP_LONG);
      send_byte(8'h42, GAP_LONG);
      check("valid_before_last", 64'(cmd_valid), 64'd0);
      strobe(8'h11);
      check("valid_latency_1clk", 64'(cmd_valid), 64'd1);
      release_rx();
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         tick(1);
         if (cmd_valid !== 1'b1 || cmd_opcode !== 8'h10 || cmd_len !== 4'd2 ||
             cmd_payload !== 64'h4241 || busy !== 1'b1) bad++;
      end
      check("hold_unstable_cycles", 64'(bad), 64'd0);
      accept();

      for (int i = 0; i < 9; i++) run_vec(vecs[i]);

      // Stray bytes in IDLE are ignored silently.
      send_byte(ERR_BYTE_DEF, GAP_SHORT);
      check("stray_3f_idle", 64'(busy), 64'd0);
      send_byte(8'h55, GAP_SHORT);
      check("stray_55_idle", 64'(busy), 64'd0);
      check("err_code_held", 64'(err_code), 64'(ERR_LEN));

      // Timeout fires exactly TIMEOUT_CYC clocks after the last strobe edge.
      push_err(ERR_TIMEOUT);
      send_byte(8'h23, GAP_SHORT);
      strobe(8'h10);
      release_rx();
      tick(TIMEOUT_CYC - 3);
      check("timeout_not_early_a", 64'(err_pulse), 64'd0);
      tick(1);
      check("timeout_not_early_b", 64'(err_pulse), 64'd0);
      check("timeout_busy_before", 64'(busy), 64'd1);
      tick(1);
      check("timeout_pulse", 64'(err_pulse), 64'd1);
      check("timeout_code", 64'(err_code), 64'(ERR_TIMEOUT));
      check("timeout_idle", 64'(busy), 64'd0);
      tick(1);
      check("timeout_pulse_width", 64'(err_pulse), 64'd0);

      // A byte landing in the expiry cycle wins over the timeout.
      push_cmd(8'h10, 4'd2, 64'h4241);
      send_byte(8'h23, GAP_SHORT);
      strobe(8'h10);
      release_rx();
      tick(TIMEOUT_CYC - 2);
      strobe(8'h02);
      check("expiry_stb_no_err", 64'(err_pulse), 64'd0);
      check("expiry_stb_busy", 64'(busy), 64'd1);
      release_rx();
      tick(GAP_SHORT);
      send_byte(8'h41, GAP_SHORT);
      send_byte(8'h42, GAP_SHORT);
      send_byte(8'h11, GAP_SHORT);
      accept();

      // Overrun while holding, then ready coinciding with an SOF strobe.
      push_cmd(8'h44, 4'd1, 64'h77);
      send_byte(8'h23, GAP_SHORT);
      send_byte(8'h44, GAP_SHORT);
      send_byte(8'h01, GAP_SHORT);
      send_byte(8'h77, GAP_SHORT);
      send_byte(8'h32, GAP_SHORT);
      check("overrun_pre_valid", 64'(cmd_valid), 64'd1);
      push_err(ERR_OVERRUN);
      strobe(8'h55);
      check("overrun_pulse", 64'(err_pulse), 64'd1);
      check("overrun_code", 64'(err_code), 64'(ERR_OVERRUN));
      check("overrun_kept_valid", 64'(cmd_valid), 64'd1);
      check("overrun_kept_opcode", 64'(cmd_opcode), 64'h44);
      release_rx();
      tick(5);
      check("overrun_kept_payload", cmd_payload, 64'h77);
      push_cmd(8'h21, 4'd0, 64'h0);
      cmd_ready = 1'b1;
      strobe(8'h23);
      cmd_ready = 1'b0;
      check("same_cycle_accepted", 64'(cmd_valid), 64'd0);
      check("same_cycle_busy", 64'(busy), 64'd1);
      release_rx();
      tick(GAP_SHORT);
      send_byte(8'h21, GAP_SHORT);
      send_byte(8'h00, GAP_SHORT);
      send_byte(8'h21, GAP_SHORT);
      accept();

      // Reset mid-payload aborts quietly.
      send_byte(8'h23, GAP_SHORT);
      send_byte(8'h10, GAP_SHORT);
      send_byte(8'h02, GAP_SHORT);
      send_byte(8'h41, GAP_SHORT);
      check("pre_rst_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      tick(1);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_err_code", 64'(err_code), 64'd0);
      check("midrst_err_pulse", 64'(err_pulse), 64'd0);
      check("midrst_opcode", 64'(cmd_opcode), 64'd0);
      check("midrst_payload", cmd_payload, 64'd0);
      rst = 1'b0;
      tick(2);
      check("post_rst_err_pulse", 64'(err_pulse), 64'd0);
      run_vec(v_good);
      run_vec(v_zero);

      tick(10);
      check("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
